ds_clock_supervisor: RTL and testbench

Sequences the delta-sigma modulator input path. It generates the modulator clock from aclk and monitors the clock returned by the modulator for presence. It gates the decimation filter through startup settling and run, and on clock loss it retries with backoff before locking out. It sits between the AXI-side register block (enable/clear) and the bitstream capture/filter datapath.

---
 rtl/ds_supervisor_pkg.sv | 23 ++
 rtl/ds_clk_monitor.sv | 49 ++++
 rtl/ds_clock_supervisor.sv | 162 ++++++++++++++++
 tb/tb_ds_clock_supervisor.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ds_supervisor_pkg.sv
// Shared state encoding and counter-width helpers for the delta-sigma clock supervisor.
package ds_supervisor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_RUN     = 3'd3,
        ST_BACKOFF = 3'd4,
        ST_LOCKOUT = 3'd5
    } state_e;

    // Bits needed to hold 0..x; never narrower than one bit.
    function automatic int cnt_w(input int x);
        return (x < 1) ? 1 : $clog2(x + 1);
    endfunction

    // States in which the modulator clock is driven and the monitor is live.
    function automatic logic clk_active(input state_e s);
        return (s == ST_START) || (s == ST_SETTLE) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/ds_clk_monitor.sv
// Presence monitor for the clock returned by the modulator: synchroniser,
// rising-edge detect and a reloading timeout counter.
module ds_clk_monitor
    import ds_supervisor_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic mod_clk_i,
    output logic edge_o,
    output logic clk_present_o
);

    localparam int              TW       = cnt_w(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]   TMO_LOAD = TW'(TIMEOUT_CYCLES);

    logic          meta_q, sync_q, sync_qq, edge_q;
    logic [TW-1:0] tmo_q;
    logic          edge_det;

    // sync_q is the second synchroniser flop; sync_qq is history for edge detect
    assign edge_det = sync_q & ~sync_qq;

    // Synchronise, register the edge, and reload/decrement the timeout (edge wins)
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            sync_qq <= 1'b0;
            edge_q  <= 1'b0;
            tmo_q   <= '0;
        end else begin
            meta_q  <= mod_clk_i;
            sync_q  <= meta_q;
            sync_qq <= sync_q;
            edge_q  <= edge_det;
            if (edge_det)
                tmo_q <= TMO_LOAD;
            else if (tmo_q != '0)
                tmo_q <= tmo_q - 1'b1;
        end
    end

    assign edge_o        = edge_q;
    assign clk_present_o = (tmo_q != '0);

endmodule

// File: rtl/ds_clock_supervisor.sv
// Delta-sigma input path sequencer: generates the modulator clock, watches the
// returned clock, gates the decimation filter and retries/locks out on loss.
module ds_clock_supervisor
    import ds_supervisor_pkg::*;
#(
    parameter int CLK_DIV        = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int SETTLE_EDGES   = 64,
    parameter int RETRY_WAIT     = 1023,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                               aclk,
    input  logic                               areset,
    input  logic                               enable,
    input  logic                               clear_fault,
    input  logic                               mod_clk_in,
    output logic                               mod_clk_out,
    output logic                               bit_strobe,
    output logic                               filter_enable,
    output logic                               filter_reset,
    output logic                               running,
    output logic                               fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
    output logic [2:0]                         state
);

    localparam int DW = cnt_w(CLK_DIV - 1);
    localparam int TW = cnt_w(TIMEOUT_CYCLES);
    localparam int SW = cnt_w(SETTLE_EDGES - 1);
    localparam int BW = cnt_w(RETRY_WAIT);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    localparam logic [DW-1:0] DIV_TC      = DW'(CLK_DIV - 1);
    localparam logic [TW-1:0] START_TO    = TW'(TIMEOUT_CYCLES);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_EDGES - 1);
    localparam logic [BW-1:0] BO_END      = BW'(RETRY_WAIT);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

    state_e        state_q, state_d;
    logic [DW-1:0] div_q;
    logic          mod_clk_q;
    logic [TW-1:0] start_q, start_inc;
    logic [SW-1:0] settle_q, settle_d;
    logic [BW-1:0] bo_q, bo_inc;
    logic [RW-1:0] retry_q, retry_d;
    logic          bit_strobe_q, filt_en_q, filt_rst_q, running_q, fault_q;
    logic          mon_edge, mon_present, fail;

    ds_clk_monitor #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_mon (
        .clk_i         (aclk),
        .rst_i         (areset),
        .clr_i         (!clk_active(state_q)),
        .mod_clk_i     (mod_clk_in),
        .edge_o        (mon_edge),
        .clk_present_o (mon_present)
    );

    // Next state, settle/retry counters; enable=0 overrides everything but lockout
    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        retry_d   = retry_q;
        fail      = 1'b0;
        start_inc = start_q + 1'b1;
        bo_inc    = bo_q + 1'b1;
        case (state_q)
            ST_IDLE:    if (enable) state_d = ST_START;
            ST_START: begin
                if (mon_edge) begin
                    state_d  = ST_SETTLE;
                    settle_d = SETTLE_LOAD;
                end else if (start_inc == START_TO) begin
                    fail = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (mon_edge) begin
                    if (settle_q == '0) state_d  = ST_RUN;
                    else                settle_d = settle_q - 1'b1;
                end else if (!mon_present) begin
                    fail = 1'b1;
                end
            end
            ST_RUN:     if (!mon_present) fail = 1'b1;
            ST_BACKOFF: if (bo_inc == BO_END) state_d = ST_START;
            ST_LOCKOUT: begin
                if (clear_fault) begin
                    state_d = ST_IDLE;
                    retry_d = '0;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
        if (fail) begin
            if (retry_q >= RETRY_MAX) begin
                state_d = ST_LOCKOUT;
            end else begin
                state_d = ST_BACKOFF;
                retry_d = retry_q + 1'b1;
            end
        end
        if (state_d == ST_RUN && state_q != ST_RUN)
            retry_d = '0;
        if (!enable && state_q != ST_LOCKOUT) begin
            state_d = ST_IDLE;
            retry_d = '0;
        end
    end

    // State, timers and status outputs, registered from the next state
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= ST_IDLE;
            start_q      <= '0;
            settle_q     <= '0;
            bo_q         <= '0;
            retry_q      <= '0;
            bit_strobe_q <= 1'b0;
            filt_en_q    <= 1'b0;
            filt_rst_q   <= 1'b1;
            running_q    <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            retry_q      <= retry_d;
            start_q      <= (state_q == ST_START   && state_d == ST_START)   ? start_inc : '0;
            bo_q         <= (state_q == ST_BACKOFF && state_d == ST_BACKOFF) ? bo_inc    : '0;
            bit_strobe_q <= mon_edge && (state_d == ST_RUN);
            filt_en_q    <= (state_d == ST_RUN);
            filt_rst_q   <= (state_d != ST_RUN);
            running_q    <= (state_d == ST_RUN);
            fault_q      <= (state_d == ST_LOCKOUT);
        end
    end

    // Clock divider: runs only while staying in an active state, so START always
    // begins from a low phase and leaving drops mod_clk_out together with state
    always_ff @(posedge aclk) begin
        if (areset || !(clk_active(state_q) && clk_active(state_d))) begin
            div_q     <= '0;
            mod_clk_q <= 1'b0;
        end else if (div_q == DIV_TC) begin
            div_q     <= '0;
            mod_clk_q <= ~mod_clk_q;
        end else begin
            div_q     <= div_q + 1'b1;
        end
    end

    assign mod_clk_out   = mod_clk_q;
    assign bit_strobe    = bit_strobe_q;
    assign filter_enable = filt_en_q;
    assign filter_reset  = filt_rst_q;
    assign running       = running_q;
    assign fault         = fault_q;
    assign retry_count   = retry_q;
    assign state         = state_q;

endmodule

// File: tb/tb_ds_clock_supervisor.sv
// Directed/randomised bench for ds_clock_supervisor with an arithmetic timing model.
module tb_ds_clock_supervisor;

    localparam int CLK_DIV = 2;
    localparam int TMO     = 15;
    localparam int SETTLE  = 4;
    localparam int RWAIT   = 10;
    localparam int MAXR    = 2;
    localparam int RW      = $clog2(MAXR + 1);
    localparam int PER     = 2 * CLK_DIV;

    logic          aclk = 1'b0;
    logic          areset, enable, clear_fault, man_clk, loop_en;
    logic          mod_clk_in, mod_clk_out, bit_strobe, filter_enable, filter_reset, running, fault;
    logic [RW-1:0] retry_count;
    logic [2:0]    state;

    int   n_cmp = 0;
    int   n_err = 0;
    int   e, exp_st, wk;
    logic exp_clk, exp_stb;
    int   q_st[$];
    int   q_rc[$];

    assign mod_clk_in = loop_en ? mod_clk_out : man_clk;

    always #5 aclk = ~aclk;

    ds_clock_supervisor #(
        .CLK_DIV(CLK_DIV), .TIMEOUT_CYCLES(TMO), .SETTLE_EDGES(SETTLE),
        .RETRY_WAIT(RWAIT), .MAX_RETRIES(MAXR)
    ) dut (
        .aclk(aclk), .areset(areset), .enable(enable), .clear_fault(clear_fault),
        .mod_clk_in(mod_clk_in), .mod_clk_out(mod_clk_out), .bit_strobe(bit_strobe),
        .filter_enable(filter_enable), .filter_reset(filter_reset), .running(running),
        .fault(fault), .retry_count(retry_count), .state(state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input int st, input int maxc, input string tag);
        int k;
        k = 0;
        while (32'(state) != st && k < maxc) begin
            @(negedge aclk);
            k++;
        end
        chk(tag, 32'(state), st);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(state), 0);
        chk({tag, "_mclk"},  32'(mod_clk_out), 0);
        chk({tag, "_stb"},   32'(bit_strobe), 0);
        chk({tag, "_fen"},   32'(filter_enable), 0);
        chk({tag, "_frst"},  32'(filter_reset), 1);
        chk({tag, "_run"},   32'(running), 0);
        chk({tag, "_fault"}, 32'(fault), 0);
        chk({tag, "_retry"}, 32'(retry_count), 0);
    endtask

    // Starting on the sample of a strobe, the next returned rising edge is placed so
    // its strobe lands g samples later. The previous edge keeps the clock present for
    // TMO samples after its strobe, so g<=TMO stays in RUN, otherwise BACKOFF at TMO.
    task automatic gap_run(input int g);
        loop_en = 1'b0;
        man_clk = 1'b0;
        for (int k = 1; k <= g && k <= TMO; k++) begin
            @(posedge aclk);
            #1;
            if (k == g - 4) man_clk = 1'b1;
            @(negedge aclk);
            if (g <= TMO) begin
                chk("gap_state",  32'(state), 3);
                chk("gap_strobe", 32'(bit_strobe), 32'(k == g));
            end else begin
                chk("lost_state",  32'(state), (k == TMO) ? 3'd4 : 3'd3);
                chk("lost_strobe", 32'(bit_strobe), 0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        areset = 1'b1; enable = 1'b0; clear_fault = 1'b0; man_clk = 1'b0; loop_en = 1'b0;
        repeat (3) @(negedge aclk);
        check_reset_vals("reset");
        areset = 1'b0;
        @(negedge aclk);
        chk("idle_hold", 32'(state), 0);

        // Loopback startup: divider, settle discard, then RUN strobes
        loop_en = 1'b1;
        enable  = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge aclk);
            exp_clk = (k >= CLK_DIV) && (((k - CLK_DIV) % PER) < CLK_DIV);
            // returned rise i is on sample CLK_DIV+PER*i; its strobe is 4 samples later
            e       = k - 4 - CLK_DIV;
            exp_stb = (e >= 0) && (e % PER == 0) && (e / PER >= SETTLE);
            exp_st  = (k < CLK_DIV + 4) ? 1 : (k < CLK_DIV + 4 + SETTLE * PER) ? 2 : 3;
            chk("t1_mclk",   32'(mod_clk_out), 32'(exp_clk));
            chk("t1_strobe", 32'(bit_strobe), 32'(exp_stb));
            chk("t1_state",  32'(state), exp_st);
            chk("t1_fen",    32'(filter_enable), 32'(exp_st == 3));
            chk("t1_frst",   32'(filter_reset), 32'(exp_st != 3));
            chk("t1_run",    32'(running), 32'(exp_st == 3));
        end

        // Gap tests in RUN, then a real loss
        wk = 0;
        while (bit_strobe !== 1'b1 && wk < 10) begin
            @(negedge aclk);
            wk++;
        end
        chk("t2_sync", 32'(bit_strobe), 1);
        repeat (3) gap_run($urandom_range(5, TMO));
        gap_run(TMO);
        gap_run(TMO + 1);
        chk("t2_retry_after_loss", 32'(retry_count), 1);
        loop_en = 1'b1;
        for (int j = 1; j <= RWAIT; j++) begin
            @(negedge aclk);
            chk("t2_backoff_state", 32'(state), (j < RWAIT) ? 3'd4 : 3'd1);
            chk("t2_backoff_retry", 32'(retry_count), 1);
        end
        wait_state(2, 40, "t2_resettle");
        chk("t2_retry_settle", 32'(retry_count), 1);
        wait_state(3, 60, "t2_rerun");
        chk("t2_retry_run", 32'(retry_count), 0);

        // Dead modulator: repeated START timeouts into LOCKOUT
        enable = 1'b0;
        @(negedge aclk);
        chk("t3_idle", 32'(state), 0);
        loop_en = 1'b0;
        man_clk = 1'b0;
        enable  = 1'b1;
        for (int a = 0; a <= MAXR; a++) begin
            repeat (TMO) begin q_st.push_back(1); q_rc.push_back(a); end
            if (a < MAXR) repeat (RWAIT) begin q_st.push_back(4); q_rc.push_back(a + 1); end
        end
        repeat (4) begin q_st.push_back(5); q_rc.push_back(MAXR); end
        while (q_st.size() > 0) begin
            exp_st = q_st.pop_front();
            e      = q_rc.pop_front();
            @(negedge aclk);
            chk("t3_state", 32'(state), exp_st);
            chk("t3_retry", 32'(retry_count), e);
            chk("t3_fault", 32'(fault), 32'(exp_st == 5));
            if (exp_st != 1) chk("t3_mclk", 32'(mod_clk_out), 0);
        end

        // LOCKOUT ignores enable; clear_fault returns to IDLE
        for (int k = 0; k < 6; k++) begin
            enable = ~enable;
            @(negedge aclk);
            chk("t4_state", 32'(state), 5);
            chk("t4_fault", 32'(fault), 1);
            chk("t4_mclk",  32'(mod_clk_out), 0);
        end
        enable      = 1'b0;
        clear_fault = 1'b1;
        @(negedge aclk);
        clear_fault = 1'b0;
        chk("t4_clear_state", 32'(state), 0);
        chk("t4_clear_fault", 32'(fault), 0);
        chk("t4_clear_retry", 32'(retry_count), 0);

        // One timeout, then enable dropped mid-SETTLE
        enable = 1'b1;
        wait_state(4, TMO + 5, "t5_backoff");
        chk("t5_retry1", 32'(retry_count), 1);
        loop_en = 1'b1;
        wait_state(2, 40, "t5_settle");
        repeat ($urandom_range(0, 3)) @(negedge aclk);
        chk("t5_still_settle", 32'(state), 2);
        chk("t5_retry_settle", 32'(retry_count), 1);
        enable = 1'b0;
        @(negedge aclk);
        chk("t5_state", 32'(state), 0);
        chk("t5_frst",  32'(filter_reset), 1);
        chk("t5_fen",   32'(filter_enable), 0);
        chk("t5_mclk",  32'(mod_clk_out), 0);
        chk("t5_retry", 32'(retry_count), 0);

        // Reset pulse in RUN
        enable = 1'b1;
        wait_state(3, 60, "t6_run");
        repeat ($urandom_range(0, 5)) @(negedge aclk);
        chk("t6_running", 32'(running), 1);
        areset = 1'b1;
        @(negedge aclk);
        check_reset_vals("t6_rst");
        areset = 1'b0;
        enable = 1'b0;
        @(negedge aclk);
        chk("t6_idle", 32'(state), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
